// File: rtl/mips_fetch.sv
// ---------------------------------------------------------------------------
// mips_fetch
//
// Instruction fetch stage for a simple in-order MIPS pipeline. It issues
// word-aligned fetch requests to an instruction memory, tracks the requests
// in flight, and buffers the returned instructions in a two-entry queue that
// feeds decode. A credit rule stops the stage from issuing a request unless
// the instruction it returns is sure to have a slot in the output queue.
// Redirects (branch, jump, exception) restart fetch at a new address. Any
// response still in flight when a redirect happens is counted as stale and
// dropped when it arrives.
//
// Ports
//   clk              single clock, all state updates on the rising edge
//   rst              synchronous active-high reset
//   imem_req_valid   fetch request to instruction memory
//   imem_req_ready   memory accepts the request this cycle
//   imem_addr        fetch byte address (word aligned)
//   imem_resp_valid  returned instruction, one per accepted request, in order
//   imem_resp_data   returned instruction word
//   if_valid         instruction presented to decode
//   if_inst          presented instruction (zero when if_valid is low)
//   if_pc            presented instruction's address (zero when if_valid is low)
//   id_ready         decode consumes the presented instruction this cycle
//   redirect_valid   redirect fetch to redirect_pc
//   redirect_pc      redirect target
// ---------------------------------------------------------------------------
module mips_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        if_valid,
   output logic [31:0] if_inst,
   output logic [31:0] if_pc,
   input  logic        id_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
);

   // Architectural fetch pointer.
   logic [31:0] r_fetchPc;

   // Requests accepted by memory whose response has not arrived yet (0..2).
   // It also gives the occupancy of the pending-PC queue.
   logic [1:0]  r_outstanding;

   // Number of in-flight responses that belong to a fetch stream abandoned by
   // a redirect and must be dropped when they arrive (0..2).
   logic [1:0]  r_drop;

   // Pending-PC queue: address of each in-flight request, oldest at head.
   logic [31:0] r_pendPc [2];
   logic        r_pendHead;

   // Output queue of {instruction, pc} pairs waiting for decode.
   logic [31:0] r_outInst [2];
   logic [31:0] r_outPc   [2];
   logic        r_outHead;
   logic [1:0]  r_outCount;

   logic        w_pop;
   logic [2:0]  w_occupancy;
   logic        w_credit;
   logic        w_accept;
   logic        w_respOk;
   logic        w_respKeep;
   logic        w_pendTail;
   logic        w_outTail;
   logic [31:0] w_respPc;

   // Decode takes the head of the output queue in the same cycle it is shown.
   // Reset gates the valid so the first reset cycle never shows stale contents.
   assign if_valid = !rst && (r_outCount != 2'd0);
   assign if_inst  = if_valid ? r_outInst[r_outHead] : 32'h0;
   assign if_pc    = if_valid ? r_outPc[r_outHead]   : 32'h0;
   assign w_pop    = if_valid && id_ready;

   // Credit rule: every in-flight request and every buffered instruction holds
   // one of the two output slots. A slot that decode frees this cycle can be
   // reused at once, which is why id_ready feeds imem_req_valid
   // combinationally. The sum never goes below zero because a pop needs a
   // buffered entry.
   assign w_occupancy    = {1'b0, r_outstanding} + {1'b0, r_outCount} - {2'b00, w_pop};
   assign w_credit       = (w_occupancy < 3'd2);
   assign imem_req_valid = !rst && !redirect_valid && w_credit;
   assign imem_addr      = r_fetchPc;
   assign w_accept       = imem_req_valid && imem_req_ready;

   // A response when nothing is outstanding is a protocol violation. It is
   // ignored here so that it cannot corrupt the counters.
   assign w_respOk   = imem_resp_valid && (r_outstanding != 2'd0);
   assign w_respKeep = w_respOk && !redirect_valid && (r_drop == 2'd0);
   assign w_respPc   = r_pendPc[r_pendHead];

   // Both queues have two entries, so the tail is the head index offset by
   // the low bit of the occupancy.
   assign w_pendTail = r_pendHead ^ r_outstanding[0];
   assign w_outTail  = r_outHead ^ r_outCount[0];

   // The fetch pointer moves to a redirect target (last redirect wins when
   // redirects are back to back), or steps one word after each accepted
   // request. It wraps modulo 2^32. While a request waits for ready, the
   // pointer stays put so the address on the bus holds stable.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetchPc <= RESET_PC;
      end else if (redirect_valid) begin
         r_fetchPc <= redirect_pc;
      end else if (w_accept) begin
         r_fetchPc <= r_fetchPc + 32'd4;
      end
   end

   // In-flight bookkeeping. An accept and a response in the same cycle leave
   // the count unchanged. A redirect marks every request still in flight after
   // this cycle as stale, so the drop count is set to what will be
   // outstanding. No accept can happen in a redirect cycle. Otherwise each
   // stale response that arrives reduces the drop count by one.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_outstanding <= 2'd0;
         r_drop        <= 2'd0;
      end else begin
         r_outstanding <= r_outstanding + {1'b0, w_accept} - {1'b0, w_respOk};
         if (redirect_valid) begin
            r_drop <= r_outstanding - {1'b0, w_respOk};
         end else if (w_respOk && (r_drop != 2'd0)) begin
            r_drop <= r_drop - 2'd1;
         end
      end
   end

   // Pending-PC queue. Memory returns responses in order, so the head always
   // holds the address of the next response. Entries keep their place across
   // redirects because the matching responses still arrive and must be
   // paired off before they are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pendHead  <= 1'b0;
         r_pendPc[0] <= 32'h0;
         r_pendPc[1] <= 32'h0;
      end else begin
         if (w_accept) begin
            r_pendPc[w_pendTail] <= r_fetchPc;
         end
         if (w_respOk) begin
            r_pendHead <= ~r_pendHead;
         end
      end
   end

   // Output queue. A push and a pop can happen in the same cycle. The credit
   // rule means a push never finds both slots full. A redirect empties the
   // queue and takes priority over a pop in the same cycle. The response in
   // that cycle is already excluded from w_respKeep.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_outHead    <= 1'b0;
         r_outCount   <= 2'd0;
         r_outInst[0] <= 32'h0;
         r_outInst[1] <= 32'h0;
         r_outPc[0]   <= 32'h0;
         r_outPc[1]   <= 32'h0;
      end else begin
         if (w_respKeep) begin
            r_outInst[w_outTail] <= imem_resp_data;
            r_outPc[w_outTail]   <= w_respPc;
         end
         if (redirect_valid) begin
            r_outHead  <= 1'b0;
            r_outCount <= 2'd0;
         end else begin
            if (w_pop) begin
               r_outHead <= ~r_outHead;
            end
            r_outCount <= r_outCount + {1'b0, w_respKeep} - {1'b0, w_pop};
         end
      end
   end

   // Simulation-only protocol and invariant checks. Synthesis ignores them.
   // Memory must never return more responses than it accepted.
   respWithoutRequest: assert property (
      @(posedge clk) disable iff (rst)
      !(imem_resp_valid && (r_outstanding == 2'd0))
   );

   // In-flight plus buffered work never exceeds the two output slots.
   occupancyBound: assert property (
      @(posedge clk) disable iff (rst)
      (({1'b0, r_outstanding} + {1'b0, r_outCount}) <= 3'd2)
   );

   // Only requests that are actually in flight can be marked stale.
   dropBound: assert property (
      @(posedge clk) disable iff (rst)
      (r_drop <= r_outstanding)
   );

   // A request that is not accepted stays on the bus unchanged until it is
   // accepted, unless a redirect or a reset intervenes.
   requestStable: assert property (
      @(posedge clk) disable iff (rst)
      (imem_req_valid && !imem_req_ready) |=>
         (rst || redirect_valid || (imem_req_valid && (imem_addr == $past(imem_addr))))
   );

endmodule

// File: tb/tb_mips_fetch.sv
// ---------------------------------------------------------------------------
// tb_mips_fetch
//
// Testbench for mips_fetch. The instruction memory is modelled behaviourally.
// It records each accepted request and answers one cycle later, in order,
// unless the bench holds it back. Its instruction word is the address XORed
// with a constant, so every delivered instruction can be traced to its pc.
// A reference model built from queues follows the stage's rules: in-flight
// requests tagged stale on redirect, and an output queue with a limit of two.
// Every cycle, a compare process checks the DUT outputs against this model.
// Directed scenarios add hand-computed literal checks that pin the model
// itself.
// ---------------------------------------------------------------------------
module tb_mips_fetch;

   localparam logic [31:0] RESET_PC = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = 32'h0;
   logic        if_valid;
   logic [31:0] if_inst;
   logic [31:0] if_pc;
   logic        id_ready = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;

   int nChecks = 0;
   int nFails  = 0;

   mips_fetch #(.RESET_PC(RESET_PC)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_resp_valid(imem_resp_valid),
      .imem_resp_data (imem_resp_data),
      .if_valid       (if_valid),
      .if_inst        (if_inst),
      .if_pc          (if_pc),
      .id_ready       (id_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   always #5 clk = ~clk;

   // Instruction word that the memory model returns for an address.
   function automatic logic [31:0] instFor(input logic [31:0] a);
      return a ^ 32'hDEAD_0000;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, actual, expected, $time);
      end
   endtask

   task automatic checkBit(input string name, input logic actual, input logic expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got %b, expected %b at t=%0t", name, actual, expected, $time);
      end
   endtask

   // Memory model: answers each accepted request in order, no sooner than the
   // cycle after it was accepted. It is reset by the same rst as the DUT.
   typedef struct { logic [31:0] addr; int cyc; } memReq_t;
   memReq_t memQ[$];
   int      memCycle = 0;
   bit      memHold  = 1'b0;

   initial begin
      forever begin
         @(posedge clk);
         memCycle++;
         #2;
         if (!rst && !memHold && (memQ.size() > 0) && (memQ[0].cyc < memCycle)) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = instFor(memQ[0].addr);
            void'(memQ.pop_front());
         end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
         end
         @(negedge clk);
         if (rst) memQ.delete();
         else if (imem_req_valid && imem_req_ready) memQ.push_back('{imem_addr, memCycle});
      end
   end

   // Reference model. inflight holds the requests memory still owes, oldest
   // first. A redirect tags each of them stale. outq is what decode will see.
   typedef struct { logic [31:0] pc; bit stale; } flight_t;
   typedef struct { logic [31:0] inst; logic [31:0] pc; } slot_t;
   flight_t     inflight[$];
   slot_t       outq[$];
   logic [31:0] mPc = RESET_PC;
   bit          eIfValid, ePop, eReqValid, gotResp;
   flight_t     respEntry;

   initial begin
      forever begin
         @(negedge clk);
         eIfValid  = !rst && (outq.size() > 0);
         ePop      = eIfValid && id_ready;
         eReqValid = !rst && !redirect_valid && ((inflight.size() + outq.size() - int'(ePop)) < 2);
         checkBit("model.imem_req_valid", imem_req_valid, eReqValid);
         if (eReqValid) checkOutput("model.imem_addr", imem_addr, mPc);
         checkBit("model.if_valid", if_valid, eIfValid);
         checkOutput("model.if_pc",   if_pc,   eIfValid ? outq[0].pc   : 32'h0);
         checkOutput("model.if_inst", if_inst, eIfValid ? outq[0].inst : 32'h0);
         if (rst) begin
            inflight.delete();
            outq.delete();
            mPc = RESET_PC;
         end else begin
            gotResp = imem_resp_valid && (inflight.size() > 0);
            if (gotResp) respEntry = inflight.pop_front();
            if (redirect_valid) begin
               outq.delete();
               foreach (inflight[i]) inflight[i].stale = 1'b1;
               mPc = redirect_pc;
            end else begin
               if (ePop) void'(outq.pop_front());
               if (gotResp && !respEntry.stale) outq.push_back('{imem_resp_data, respEntry.pc});
               if (eReqValid && imem_req_ready) begin
                  inflight.push_back('{mPc, 1'b0});
                  mPc = mPc + 32'd4;
               end
            end
         end
      end
   end

   // Drive one cycle of inputs just after the rising edge.
   task automatic applyStimulus(input bit r, input bit idr, input bit rdy,
                                input bit redir, input logic [31:0] rpc, input bit hold);
      @(posedge clk);
      #1;
      rst            = r;
      id_ready       = idr;
      imem_req_ready = rdy;
      redirect_valid = redir;
      redirect_pc    = rpc;
      memHold        = hold;
   endtask

   // Two reset cycles, with the reset-state outputs checked in the second one.
   task automatic doReset(input bit idr);
      applyStimulus(1'b1, idr, 1'b1, 1'b0, 32'h0, 1'b0);
      applyStimulus(1'b1, idr, 1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      checkBit("reset.imem_req_valid", imem_req_valid, 1'b0);
      checkBit("reset.if_valid", if_valid, 1'b0);
      checkOutput("reset.if_inst", if_inst, 32'h0);
      checkOutput("reset.if_pc", if_pc, 32'h0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Streaming after reset. Fetch issues at RESET_PC in the first cycle
      // and delivers one instruction per cycle from cycle 2 on.
      doReset(1'b1);
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
         @(negedge clk);
         checkBit("stream.reqValid", imem_req_valid, 1'b1);
         checkOutput("stream.addr", imem_addr, RESET_PC + 32'(4 * k));
         if (k >= 2) checkOutput("stream.ifPc", if_pc, RESET_PC + 32'(4 * (k - 2)));
         else        checkBit("stream.ifValid", if_valid, 1'b0);
         if (k == 2) checkOutput("stream.ifInst", if_inst, 32'hDEED_0000);
      end

      // Decode stalled from the start: two requests, then fetch stops with
      // the queue full. It resumes at 0x00400008 once decode drains.
      doReset(1'b0);
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b0, (k >= 5), 1'b1, 1'b0, 32'h0, 1'b0);
         @(negedge clk);
         if (k < 2) checkOutput("stall.addr", imem_addr, RESET_PC + 32'(4 * k));
         if (k >= 2 && k <= 4) checkBit("stall.reqValid", imem_req_valid, 1'b0);
         if (k >= 2 && k <= 5) checkOutput("stall.ifPcHead", if_pc, 32'h0040_0000);
         if (k == 5) checkOutput("stall.resumeAddr", imem_addr, 32'h0040_0008);
         if (k == 6) checkOutput("stall.ifPcSecond", if_pc, 32'h0040_0004);
         if (k == 7) checkOutput("stall.ifPcThird", if_pc, 32'h0040_0008);
      end

      // Memory not ready for three cycles: the request holds steady.
      doReset(1'b1);
      for (int k = 0; k < 6; k++) begin
         applyStimulus(1'b0, 1'b1, (k >= 3), 1'b0, 32'h0, 1'b0);
         @(negedge clk);
         if (k <= 3) begin
            checkBit("notReady.reqValid", imem_req_valid, 1'b1);
            checkOutput("notReady.addr", imem_addr, 32'h0040_0000);
         end
         if (k == 4) checkOutput("notReady.nextAddr", imem_addr, 32'h0040_0004);
         if (k == 5) checkOutput("notReady.ifPc", if_pc, 32'h0040_0000);
      end

      // Two requests in flight, then a redirect that coincides with the first
      // response: both stale responses are dropped. The first instruction
      // delivered comes from the target.
      doReset(1'b1);
      for (int k = 0; k < 6; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b1, (k == 2), 32'h0040_0100, (k < 2));
         @(negedge clk);
         if (k == 2) checkBit("redirect.reqValid", imem_req_valid, 1'b0);
         if (k == 3) checkOutput("redirect.addr", imem_addr, 32'h0040_0100);
         if (k >= 2 && k <= 4) checkBit("redirect.ifValid", if_valid, 1'b0);
         if (k == 5) begin
            checkOutput("redirect.ifPc", if_pc, 32'h0040_0100);
            checkOutput("redirect.ifInst", if_inst, 32'hDEED_0100);
         end
      end

      // Back-to-back redirects during streaming. The first redirect coincides
      // with a response and a pop, and the second one wins.
      doReset(1'b1);
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b1, (k == 5 || k == 6),
                       (k == 5) ? 32'h0040_2000 : 32'h0040_1000, 1'b0);
         @(negedge clk);
         if (k == 5) checkOutput("b2b.ifPcBefore", if_pc, 32'h0040_000C);
         if (k >= 6 && k <= 8) checkBit("b2b.ifValid", if_valid, 1'b0);
         if (k == 7) checkOutput("b2b.addr", imem_addr, 32'h0040_1000);
         if (k == 9) checkOutput("b2b.ifPc", if_pc, 32'h0040_1000);
      end

      // One-cycle reset pulse with two requests in flight.
      doReset(1'b1);
      for (int k = 0; k < 6; k++) begin
         applyStimulus((k == 2), 1'b1, 1'b1, 1'b0, 32'h0, (k < 3));
         @(negedge clk);
         if (k == 2 || k == 3) checkBit("midReset.ifValid", if_valid, 1'b0);
         if (k == 3) checkOutput("midReset.addr", imem_addr, 32'h0040_0000);
         if (k == 5) checkOutput("midReset.ifPc", if_pc, 32'h0040_0000);
      end

      // Mixed directed pattern covering decode stalls, memory back-pressure,
      // held responses, periodic redirects and one reset. The compare process
      // checks every cycle of it.
      doReset(1'b1);
      for (int k = 0; k < 80; k++) begin
         applyStimulus((k == 50), ((k % 5) != 3), ((k % 7) != 2), ((k % 23) == 11),
                       32'h0041_0000 + 32'(16 * k), ((k % 11) >= 8));
      end

      for (int k = 0; k < 6; k++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
